// File: rtl/mode_switch_sequencer.sv
// Qualifies a requested video mode, holds the pipeline in reset and sequences a four-phase
// PLL reconfiguration handshake before committing the new active mode.
module mode_switch_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned DRAIN_CYCLES  = 16,
  parameter int unsigned ACK_TIMEOUT   = 65535,
  parameter logic [7:0]  MODE_VGA      = 8'h00
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [7:0] i_config_data,
  input  logic       i_config_changed,
  input  logic       i_pll_reconf_ack,
  input  logic       i_pll_locked,
  output logic       o_pll_reconf_req,
  output logic [7:0] o_pll_reconf_mode,
  output logic       o_video_reset,
  output logic [7:0] o_active_mode,
  output logic       o_mode_switch_done,
  output logic       o_error
);

  localparam int unsigned MaxSd    = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES
                                                                     : DRAIN_CYCLES;
  localparam int unsigned MaxCount = (MaxSd > ACK_TIMEOUT) ? MaxSd : ACK_TIMEOUT;
  localparam int unsigned CntW     = $clog2(MaxCount + 1);

  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] DrainLast  = CntW'(DRAIN_CYCLES - 1);
  localparam logic [CntW-1:0] AckLast    = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StDrain,
    StReq,
    StAckLow,
    StLock
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [7:0]      r_candidate;
  logic            r_boot;
  logic            r_first;
  logic            r_ack_armed;
  logic            r_pll_reconf_req;
  logic [7:0]      r_pll_reconf_mode;
  logic            r_video_reset;
  logic [7:0]      r_active_mode;
  logic            r_mode_switch_done;
  logic            r_error;

  logic [CntW-1:0] w_cnt_inc;
  logic            w_cfg_differs;

  // Saturating increment: the counter never wraps back into a valid compare value.
  assign w_cnt_inc     = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_cfg_differs = (i_config_data != r_candidate);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state            <= StSettle;
      r_cnt              <= '0;
      r_candidate        <= MODE_VGA;
      r_boot             <= 1'b1;
      r_first            <= 1'b1;
      r_ack_armed        <= 1'b1;
      r_pll_reconf_req   <= 1'b0;
      r_pll_reconf_mode  <= MODE_VGA;
      r_video_reset      <= 1'b1;
      r_active_mode      <= MODE_VGA;
      r_mode_switch_done <= 1'b0;
      r_error            <= 1'b0;
    end else begin
      r_mode_switch_done <= 1'b0;
      // An ack only counts after it has been seen low since the last timeout.
      if (!i_pll_reconf_ack) begin
        r_ack_armed <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (i_config_changed || (i_config_data != r_active_mode)) begin
            r_candidate <= i_config_data;
            r_cnt       <= '0;
            r_state     <= StSettle;
          end
        end

        StSettle: begin
          if (r_first || w_cfg_differs) begin
            r_candidate <= i_config_data;
            r_cnt       <= '0;
            r_first     <= 1'b0;
          end else if (r_cnt == SettleLast) begin
            if ((r_candidate == r_active_mode) && !r_boot) begin
              r_state <= StIdle;
            end else begin
              r_cnt         <= '0;
              r_video_reset <= 1'b1;
              r_state       <= StDrain;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        StDrain: begin
          r_video_reset <= 1'b1;
          if (r_cnt == DrainLast) begin
            r_pll_reconf_mode <= r_candidate;
            r_pll_reconf_req  <= 1'b1;
            r_cnt             <= '0;
            r_state           <= StReq;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        StReq: begin
          if (i_pll_reconf_ack && r_ack_armed) begin
            r_pll_reconf_req <= 1'b0;
            r_cnt            <= w_cnt_inc;
            r_state          <= StAckLow;
          end else if (r_cnt == AckLast) begin
            r_error          <= 1'b1;
            r_pll_reconf_req <= 1'b0;
            r_ack_armed      <= 1'b0;
            r_cnt            <= '0;
            r_state          <= StDrain;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        StAckLow: begin
          if (!i_pll_reconf_ack) begin
            r_cnt   <= w_cnt_inc;
            r_state <= StLock;
          end else if (r_cnt == AckLast) begin
            r_error          <= 1'b1;
            r_pll_reconf_req <= 1'b0;
            r_ack_armed      <= 1'b0;
            r_cnt            <= '0;
            r_state          <= StDrain;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        StLock: begin
          if (i_pll_locked) begin
            r_active_mode      <= r_candidate;
            r_mode_switch_done <= 1'b1;
            r_error            <= 1'b0;
            r_boot             <= 1'b0;
            r_video_reset      <= 1'b0;
            r_state            <= StIdle;
          end else if (r_cnt == AckLast) begin
            r_error          <= 1'b1;
            r_pll_reconf_req <= 1'b0;
            r_ack_armed      <= 1'b0;
            r_cnt            <= '0;
            r_state          <= StDrain;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_state <= StSettle;
        end
      endcase
    end
  end

  assign o_pll_reconf_req   = r_pll_reconf_req;
  assign o_pll_reconf_mode  = r_pll_reconf_mode;
  assign o_video_reset      = r_video_reset;
  assign o_active_mode      = r_active_mode;
  assign o_mode_switch_done = r_mode_switch_done;
  assign o_error            = r_error;

endmodule

// File: tb/tb_mode_switch_sequencer.sv
// Directed-plus-random bench: expected event times are derived from the mode-switch rules
// (settle/drain latency, ack/lock sampling, timeout) and compared at each step.
module tb_mode_switch_sequencer;

  localparam int unsigned S = 8;
  localparam int unsigned D = 4;
  localparam int unsigned T = 32;
  localparam logic [7:0] M_VGA  = 8'h00;
  localparam logic [7:0] M_720  = 8'h01;
  localparam logic [7:0] M_1080 = 8'h02;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg;
  logic       chg;
  logic       ack;
  logic       locked;
  logic       o_req;
  logic [7:0] o_mode;
  logic       o_vr;
  logic [7:0] o_active;
  logic       o_done;
  logic       o_err;

  mode_switch_sequencer #(
    .SETTLE_CYCLES(S),
    .DRAIN_CYCLES (D),
    .ACK_TIMEOUT  (T),
    .MODE_VGA     (M_VGA)
  ) dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_config_data     (cfg),
    .i_config_changed  (chg),
    .i_pll_reconf_ack  (ack),
    .i_pll_locked      (locked),
    .o_pll_reconf_req  (o_req),
    .o_pll_reconf_mode (o_mode),
    .o_video_reset     (o_vr),
    .o_active_mode     (o_active),
    .o_mode_switch_done(o_done),
    .o_error           (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int req_rises = 0;
  int done_cnt  = 0;
  int vr_cycles = 0;
  logic prev_req  = 1'b0;
  logic prev_done = 1'b0;

  // Reference model state
  logic [7:0] m_active;
  logic [7:0] m_req_mode;
  int t_last, t_ack, t_lock, t_rel, t_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_req && !prev_req) req_rises++;
      if (o_done) done_cnt++;
      if (o_vr) vr_cycles++;
      if (o_req) begin
        check("vr_during_req", 32'(o_vr), 32'd1);
        check("req_mode", 32'(o_mode), 32'(m_req_mode));
      end
      if (prev_done) check("done_width", 32'(o_done), 32'd0);
    end
    prev_req  = o_req;
    prev_done = o_done;
  end

  function automatic logic [7:0] mode_at(input int i);
    case (i)
      0:       return M_VGA;
      1:       return M_720;
      default: return M_1080;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    chg = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] v);
    if (v != cfg) begin
      chg    = 1'b1;
      cfg    = v;
      t_last = cyc;
    end
  endtask

  task automatic wait_req_rise(input int exp_t, input string tag);
    int n;
    n = 0;
    while (o_req !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, 32'(o_req), 32'd1);
    check({tag, "_req_time"}, 32'(cyc), 32'(exp_t));
    check({tag, "_req_vr"}, 32'(o_vr), 32'd1);
    t_r = cyc;
  endtask

  task automatic handshake(input int a, input int d, input int l, input bit do_lock);
    int n;
    locked = 1'b0;
    repeat (a) tick();
    ack   = 1'b1;
    t_ack = cyc;
    n = 0;
    while (o_req === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("req_fall_time", 32'(cyc), 32'(t_ack + 1));
    repeat (d) tick();
    ack = 1'b0;
    repeat (l) tick();
    if (do_lock) begin
      locked = 1'b1;
      t_lock = cyc;
    end
  endtask

  task automatic wait_commit(input string tag);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(o_done), 32'd1);
    check({tag, "_done_time"}, 32'(cyc), 32'(t_lock + 1));
    check({tag, "_active"}, 32'(o_active), 32'(m_active));
    check({tag, "_vr_low"}, 32'(o_vr), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_req_low"}, 32'(o_req), 32'd0);
    tick();
    check({tag, "_done_one"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int r0, d0, v0, len, nb;
    logic [7:0] v;

    rst_n = 1'b0;
    cfg = M_VGA;
    chg = 1'b0;
    ack = 1'b0;
    locked = 1'b0;
    m_active = M_VGA;
    m_req_mode = M_VGA;
    t_last = 0;
    t_ack = 0;
    t_lock = 0;
    t_r = 0;
    repeat (3) tick();

    check("rst_req", 32'(o_req), 32'd0);
    check("rst_mode", 32'(o_mode), 32'(M_VGA));
    check("rst_vr", 32'(o_vr), 32'd1);
    check("rst_active", 32'(o_active), 32'(M_VGA));
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);

    // Boot: candidate is sampled at the first edge after release
    m_req_mode = cfg;
    rst_n = 1'b1;
    t_rel = cyc;
    wait_req_rise(t_rel + 1 + S + D, "boot");
    handshake(3, $urandom_range(1, 4), 5, 1'b1);
    m_active = M_VGA;
    wait_commit("boot");

    // Glitch shorter than the settle window
    len = $urandom_range(1, 6);
    r0 = req_rises; d0 = done_cnt; v0 = vr_cycles;
    set_cfg(M_720);
    repeat (len) tick();
    set_cfg(M_VGA);
    repeat (S + 12) tick();
    check("glitch_no_req", 32'(req_rises - r0), 32'd0);
    check("glitch_no_vr", 32'(vr_cycles - v0), 32'd0);
    check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    check("glitch_active", 32'(o_active), 32'(M_VGA));

    // VGA -> 1080p
    set_cfg(M_1080);
    m_req_mode = M_1080;
    wait_req_rise(t_last + 1 + S + D, "to1080");
    handshake($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(1, 8), 1'b1);
    m_active = M_1080;
    wait_commit("to1080");

    // Bounce every 5 cycles, finally holding 720p
    r0 = req_rises; d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      set_cfg((i % 2 == 0) ? M_VGA : M_720);
      if (i < 7) repeat (5) tick();
    end
    m_req_mode = M_720;
    wait_req_rise(t_last + 1 + S + D, "bounce");
    handshake($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(1, 8), 1'b1);
    m_active = M_720;
    wait_commit("bounce");
    check("bounce_one_req", 32'(req_rises - r0), 32'd1);
    check("bounce_one_done", 32'(done_cnt - d0), 32'd1);

    // Random switches preceded by short bursts of unstable input
    for (int k = 0; k < 4; k++) begin
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        do v = mode_at($urandom_range(0, 2)); while (v == cfg);
        set_cfg(v);
        repeat ($urandom_range(1, 7)) tick();
      end
      do v = mode_at($urandom_range(0, 2)); while (v == cfg || v == m_active);
      r0 = req_rises;
      set_cfg(v);
      m_req_mode = v;
      wait_req_rise(t_last + 1 + S + D, "rand");
      handshake($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(1, 8), 1'b1);
      m_active = v;
      wait_commit("rand");
      check("rand_one_req", 32'(req_rises - r0), 32'd1);
    end

    // Timeout and retry with the same candidate
    do v = mode_at($urandom_range(0, 2)); while (v == cfg || v == m_active);
    set_cfg(v);
    m_req_mode = v;
    wait_req_rise(t_last + 1 + S + D, "tmo");
    locked = 1'b0;
    begin
      int n;
      n = 0;
      while (o_err !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
    end
    check("tmo_err", 32'(o_err), 32'd1);
    check("tmo_err_time", 32'(cyc), 32'(t_r + T));
    check("tmo_req_drop", 32'(o_req), 32'd0);
    check("tmo_vr_held", 32'(o_vr), 32'd1);
    wait_req_rise(t_r + T + D, "retry");
    check("retry_err_kept", 32'(o_err), 32'd1);
    handshake($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(1, 8), 1'b1);
    m_active = v;
    wait_commit("retry");

    // Reset asserted while waiting for lock
    do v = mode_at($urandom_range(0, 2)); while (v == cfg || v == m_active);
    set_cfg(v);
    m_req_mode = v;
    wait_req_rise(t_last + 1 + S + D, "midrst");
    handshake(2, 1, 2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    m_active = M_VGA;
    check("midrst_req", 32'(o_req), 32'd0);
    check("midrst_vr", 32'(o_vr), 32'd1);
    check("midrst_active", 32'(o_active), 32'(m_active));
    check("midrst_mode", 32'(o_mode), 32'(M_VGA));
    check("midrst_err", 32'(o_err), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    t_rel = cyc;
    wait_req_rise(t_rel + 1 + S + D, "reboot");
    handshake($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(1, 8), 1'b1);
    m_active = v;
    wait_commit("reboot");

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_switch_sequencer.md
# mode_switch_sequencer

Consumes the committed video mode (`config_data`, `config_changed`) from the switch-decoding stage and applies it safely to the rest of the design. It qualifies the requested mode over a stability window, holds the downstream video pipeline in reset, and runs a four-phase request/acknowledge handshake with the PLL reconfiguration logic. Once the PLL re-locks, it publishes the new `active_mode` and releases the pipeline. It sits between the configuration decoder and the clock/timing generators.

## Interface
- SETTLE_CYCLES, 1024, cycles `config_data` must stay unchanged before a switch is started
- DRAIN_CYCLES, 16, cycles `video_reset` is held before the PLL request is raised
- ACK_TIMEOUT, 65535, maximum cycles spent in the handshake/lock phase before retry
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- config_data  in  8  requested mode, one of `MODE_VGA` / `MODE_720p` / `MODE_1080p`
- config_changed  in  1  high in any cycle where `config_data` differs from its previous value
- pll_reconf_ack  in  1  level acknowledge from PLL reconfiguration logic
- pll_locked  in  1  PLL lock status, treated as synchronous
- pll_reconf_req  out  1  level request, four-phase with `pll_reconf_ack`
- pll_reconf_mode  out  8  mode to program; valid and stable while `pll_reconf_req`=1
- video_reset  out  1  active-high hold of downstream video pipeline
- active_mode  out  8  currently committed mode
- mode_switch_done  out  1  one-cycle pulse on commit
- error  out  1  set on handshake timeout; cleared on the next successful commit

## Operation
- All outputs are registered.
- Reset values:
  - `pll_reconf_req`=0, `pll_reconf_mode`=`MODE_VGA`, `video_reset`=1
  - `active_mode`=`MODE_VGA`, `mode_switch_done`=0, `error`=0
  - state=SETTLE with the internal `boot` flag set; `candidate` = `config_data` sampled at the first clock edge.
- A single counter, wide enough for max(SETTLE_CYCLES, DRAIN_CYCLES, ACK_TIMEOUT), saturates and never wraps.
- States:
  - IDLE: `video_reset`=0. If `config_changed`=1 or `config_data`≠`active_mode`, then `candidate`←`config_data`, counter←0, go to SETTLE.
  - SETTLE: if `config_data`≠`candidate`, then `candidate`←`config_data` and counter←0. Otherwise counter++. When counter = SETTLE_CYCLES−1 with input still stable:
    - if `candidate`=`active_mode` and `boot`=0 (glitch or revert), go to IDLE with no switch;
    - otherwise go to DRAIN, counter←0.
  - DRAIN: `video_reset`=1; `candidate` frozen; counter++. At DRAIN_CYCLES−1: `pll_reconf_mode`←`candidate`, `pll_reconf_req`←1, counter←0, go to REQ.
  - REQ: wait for `pll_reconf_ack`=1, then `pll_reconf_req`←0, go to ACK_LOW.
  - ACK_LOW: wait for `pll_reconf_ack`=0, then go to LOCK.
  - LOCK: wait for `pll_locked`=1, then:
    - `active_mode`←`candidate`, `mode_switch_done`←1, `error`←0, `boot`←0, `video_reset`←0;
    - go to IDLE.
- Timeout: the counter runs continuously across REQ, ACK_LOW and LOCK. On reaching ACK_TIMEOUT−1:
  - `error`←1, `pll_reconf_req`←0, go to DRAIN (counter←0) to retry with the same `candidate`;
  - on a retry from REQ, `pll_reconf_ack` is still honoured only via a fresh four-phase cycle.
- Input changes during DRAIN through LOCK are ignored. They are picked up in IDLE by the `active_mode` mismatch check.
- `video_reset` stays 1 continuously from DRAIN entry until the commit cycle, including across retries.
- `pll_reconf_mode` changes only in the DRAIN→REQ transition cycle.
- Reset asserted mid-switch: all outputs return to reset values asynchronously, `pll_reconf_req` drops immediately, and the boot sequence restarts.

## Timing
- Minimum latency from the last `config_data` change (in IDLE) to `pll_reconf_req`=1: 1 + SETTLE_CYCLES + DRAIN_CYCLES cycles.
- Commit follows the edge after `pll_locked` is sampled high. In that same cycle, `mode_switch_done`=1, `active_mode` is updated and `video_reset`=0.
- `mode_switch_done` is exactly one cycle wide.
- `pll_reconf_req` falls the cycle after `pll_reconf_ack` is sampled high.
- If `pll_reconf_ack` and `pll_locked` are both high in the same cycle, the ack phase is handled first; lock is evaluated only in LOCK.

## Test plan
Parameters for all scenarios: SETTLE_CYCLES=8, DRAIN_CYCLES=4, ACK_TIMEOUT=32.

- Boot: release reset with `config_data`=`MODE_VGA`, responder ack after 3 cycles, lock after 5 -> `video_reset`=1 until commit; one `mode_switch_done` pulse; `active_mode`=`MODE_VGA`; `video_reset`=0.
- VGA→1080p: change `config_data` in IDLE -> `pll_reconf_req` rises 13 cycles later with `pll_reconf_mode`=`MODE_1080p`; after handshake and lock, `active_mode`=`MODE_1080p` and one done pulse.
- Glitch: in IDLE, pulse `config_data` to `MODE_720p` for 3 cycles then back to `MODE_VGA` -> no request raised; `video_reset` stays 0; returns to IDLE.
- Bounce: toggle `config_data` every 5 cycles for 40 cycles, then hold `MODE_720p` -> exactly one switch, to `MODE_720p`, requested 8 cycles after the last change plus drain.
- Timeout/retry: responder never acks -> `error`=1 after 32 cycles in REQ; `pll_reconf_req` drops; re-raised after 4 drain cycles. When the responder then completes, `error`=0 and `active_mode` is updated.
- Mid-switch reset: assert `reset_n`=0 while in LOCK -> `pll_reconf_req`=0, `video_reset`=1, `active_mode`=`MODE_VGA` immediately; the boot sequence restarts after release.
